// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: scans a 4x4 active-low keypad one column at a time, debounces whole frames and strobes the key code
module matrix_key_scanner #(
  parameter int CLK_DIV  = 50000,
  parameter int DEBOUNCE = 5
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;
  state_t state_q, state_d;
  logic [3:0] row_m_q, row_s_q, col_q, col_d, cnt_q, cnt_d, cand_q, cand_d, code_q, code_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] sel_q, sel_d;
  logic [15:0] samp_q, samp_d, frame;
  logic [4:0] ones;
  logic [3:0] idx;
  logic tick, frame_end, none, single, acc, valid_q;
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      row_m_q <= 4'hf;
      row_s_q <= 4'hf;
      div_q   <= '0;
      sel_q   <= '0;
      col_q   <= 4'b1110;
      samp_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      row_m_q <= ROW;
      row_s_q <= row_m_q;
      div_q   <= div_d;
      sel_q   <= sel_d;
      col_q   <= col_d;
      samp_q  <= samp_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= acc;
    end
  end
  // Frame bit 4*row+col is set when that row reads low while that column is driven
  always_comb begin
    tick      = div_q == DW'(CLK_DIV - 1);
    frame_end = tick && sel_q == 2'd3;
    div_d     = tick ? '0 : div_q + DW'(1);
    sel_d     = tick ? sel_q + 2'd1 : sel_q;
    col_d     = tick ? ~(4'b0001 << sel_d) : col_q;
    frame     = samp_q;
    for (int r = 0; r < 4; r++) frame[{2'(r), sel_q}] = ~row_s_q[r];
    samp_d    = tick ? (frame_end ? '0 : frame) : samp_q;
    ones      = '0;
    idx       = '0;
    for (int i = 0; i < 16; i++)
      if (frame[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    none      = ones == 5'd0;
    single    = ones == 5'd1;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    acc     = 1'b0;
    if (frame_end)
      case (state_q)
        IDLE:
          if (single) begin
            cand_d  = idx;
            cnt_d   = 4'd1;
            state_d = DEBOUNCE == 1 ? PRESSED : PRESS_DB;
            acc     = DEBOUNCE == 1;
          end
        PRESS_DB:
          if (single && idx == cand_q) begin
            cnt_d   = cnt_q + 4'd1;
            acc     = cnt_d == 4'(DEBOUNCE);
            state_d = acc ? PRESSED : PRESS_DB;
          end else if (single) begin
            cand_d = idx;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        PRESSED:
          if (none) begin
            cnt_d   = 4'd1;
            state_d = DEBOUNCE == 1 ? IDLE : RELEASE_DB;
          end else cnt_d = '0;
        RELEASE_DB:
          if (none) begin
            cnt_d   = cnt_q + 4'd1;
            state_d = cnt_d == 4'(DEBOUNCE) ? IDLE : RELEASE_DB;
          end else begin
            cnt_d   = '0;
            state_d = PRESSED;
          end
      endcase
    code_d = acc ? cand_d : code_q;
  end
  always_comb begin
    COL       = col_q;
    key_code  = code_q;
    key_valid = valid_q;
    key_down  = state_q == PRESSED || state_q == RELEASE_DB;
  end
endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb_matrix_key_scanner: directed keypad scenarios on a DEBOUNCE=3 and a DEBOUNCE=1 scanner at CLK_DIV=4
module tb_matrix_key_scanner;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] keys0 = '0, keys1 = '0;
  logic [3:0] row0, row1, col0, col1, code0, code1;
  logic kv0, kv1, kd0, kd1;
  int checks = 0, failures = 0, vc0 = 0, vc1 = 0, n, vb;
  logic any_hi;
  logic [3:0] e;

  always #5 clk = ~clk;

  function automatic logic [3:0] rows(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hf;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[4*ri+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign row0 = rows(keys0, col0);
  assign row1 = rows(keys1, col1);

  matrix_key_scanner #(.CLK_DIV(4), .DEBOUNCE(3)) u0 (
    .clk_50M(clk), .rst(rst), .ROW(row0), .COL(col0),
    .key_code(code0), .key_valid(kv0), .key_down(kd0));
  matrix_key_scanner #(.CLK_DIV(4), .DEBOUNCE(1)) u1 (
    .clk_50M(clk), .rst(rst), .ROW(row1), .COL(col1),
    .key_code(code1), .key_valid(kv1), .key_down(kd1));

  always @(posedge clk) begin
    if (kv0) vc0 <= vc0 + 1;
    if (kv1) vc1 <= vc1 + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the edge where COL goes back to column 0, i.e. a frame start
  task automatic frame_start;
    logic [3:0] p;
    p = col0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (col0 == 4'b1110 && p == 4'b0111) return;
      p = col0;
    end
    chk("frame_align_timeout", 1, 0);
  endtask

  task automatic wait_valid(input int u, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if ((u == 0) ? kv0 : kv1) return;
    end
  endtask

  task automatic wait_up(input int u, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (!((u == 0) ? kd0 : kd1)) return;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", col0, 4'b1110);
    chk("rst_code", code0, 0);
    chk("rst_valid", kv0, 0);
    chk("rst_down", kd0, 0);
    rst = 1'b0;
    any_hi = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      e = ~(4'b0001 << ((i / 4) % 4));
      chk("col_seq", col0, e);
      any_hi = any_hi | kv0 | kd0 | kv1 | kd1;
    end
    chk("idle_quiet", any_hi, 0);
    chk("idle_code", code0, 0);

    // clean press of key 9 (row 2, column 1) for 6 frames
    frame_start;
    vb = vc0;
    keys0 = 16'(1) << 9;
    wait_valid(0, n);
    chk("press9_lat", n, 48);
    chk("press9_code", code0, 9);
    chk("press9_down", kd0, 1);
    @(posedge clk); #1;
    chk("valid_width", kv0, 0);
    repeat (3) frame_start;
    keys0 = '0;
    wait_up(0, n);
    chk("release9_lat", n, 48);
    chk("press9_pulses", vc0 - vb, 1);
    chk("code_held", code0, 9);

    // bounce on alternate frames, then steady
    vb = vc0;
    for (int f = 0; f < 8; f++) begin
      frame_start;
      keys0 = (f % 2 == 0) ? 16'(1) << 9 : '0;
    end
    frame_start;
    chk("bounce_pulses", vc0 - vb, 0);
    chk("bounce_down", kd0, 0);
    keys0 = 16'(1) << 9;
    wait_valid(0, n);
    chk("bounce_steady_lat", n, 48);
    chk("bounce_code", code0, 9);
    keys0 = '0;
    wait_up(0, n);
    chk("bounce_release_lat", n, 48);

    // two keys together, then change while held
    frame_start;
    vb = vc0;
    keys0 = 16'h8001;
    repeat (4) frame_start;
    chk("multi_pulses", vc0 - vb, 0);
    chk("multi_down", kd0, 0);
    keys0 = '0;
    repeat (2) frame_start;
    keys0 = 16'(1) << 5;
    wait_valid(0, n);
    chk("press5_lat", n, 48);
    chk("press5_code", code0, 5);
    keys0 = (16'(1) << 5) | (16'(1) << 10);
    repeat (3) frame_start;
    chk("add10_down", kd0, 1);
    keys0 = '0;
    wait_up(0, n);
    chk("release5_lat", n, 48);
    chk("press5_pulses", vc0 - vb, 1);
    chk("press5_code_kept", code0, 5);

    // corner codes on the single-frame debouncer
    frame_start;
    keys1 = 16'h0001;
    wait_valid(1, n);
    chk("db1_k0_lat", n, 16);
    chk("db1_k0_code", code1, 0);
    chk("db1_k0_down", kd1, 1);
    frame_start;
    keys1 = '0;
    wait_up(1, n);
    chk("db1_k0_release", n, 16);
    frame_start;
    keys1 = 16'h8000;
    wait_valid(1, n);
    chk("db1_k15_lat", n, 16);
    chk("db1_k15_code", code1, 15);
    frame_start;
    keys1 = '0;
    wait_up(1, n);
    chk("db1_k15_release", n, 16);
    chk("db1_pulses", vc1, 2);

    // reset while key 3 is being debounced
    frame_start;
    vb = vc0;
    keys0 = 16'(1) << 3;
    repeat (2) frame_start;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_col", col0, 4'b1110);
    chk("mid_rst_code", code0, 0);
    chk("mid_rst_valid", kv0, 0);
    chk("mid_rst_down", kd0, 0);
    chk("mid_rst_code1", code1, 0);
    chk("mid_rst_pulses", vc0 - vb, 0);
    rst = 1'b0;
    wait_valid(0, n);
    chk("post_rst_lat", n, 48);
    chk("post_rst_code", code0, 3);
    keys0 = '0;
    wait_up(0, n);
    chk("post_rst_release", n, 48);
    chk("post_rst_pulses", vc0 - vb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/matrix_key_scanner.md
# matrix_key_scanner

Scans a 4x4 active-low matrix keypad by driving one column low at a time and reading the rows, then debounces and encodes the result into a 4-bit key code with a one-cycle strobe. It is the input-side counterpart of the multiplexed display scanner: the same 50 MHz board clock, a divided scan tick and a mod-4 column select. It feeds key codes to the counter and control logic upstream of the display path.

## Interface

- CLK_DIV, 50000: clk_50M cycles per scan tick (1 kHz at 50 MHz); legal range ≥ 4.
- DEBOUNCE, 5: consecutive identical frames required to accept a press or a release; legal range 1..15.
- clk_50M  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk_50M.
- COL  output  4  keypad column drive, one-hot active-low.
- key_code  output  4  code of the accepted key, equal to 4*row_index + col_index.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_down  output  1  high while the accepted key is held (press accepted, release not yet accepted).

## Operation

- ROW passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Divider: the counter runs 0..CLK_DIV-1 and wraps. tick is asserted in the cycle where the count equals CLK_DIV-1.
- Column pointer SEL, mod 4, advances on tick. COL = ~(4'b0001 << SEL), registered.
- On tick, the synchronized ROW is sampled as the result for the current column SEL. The sample is taken before SEL advances, so each column has been driven for a full tick period.
- Frame end is the tick with SEL==3. The frame is classified from its 16 samples:
  - NONE: no row low in any column.
  - SINGLE(k): exactly one low bit across all 16 samples; k = 4*row_index + col_index (ROW[0] is row 0, COL[0] is column 0).
  - MULTI: more than one low bit.
- The FSM updates only at frame end. cnt is a 4-bit frame counter. cand is the 4-bit candidate code.
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. Go to PRESS_DB, or go directly to PRESSED if DEBOUNCE==1.
    - NONE or MULTI: stay in IDLE.
  - PRESS_DB:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE, go to PRESSED.
    - SINGLE(j≠cand): cand=j, cnt=1 (restart).
    - NONE or MULTI: go to IDLE.
  - PRESSED (entry): key_code=cand and key_valid pulses on entry. key_down=1 for the whole state and through RELEASE_DB.
    - Any SINGLE or MULTI frame: stay; cnt=0.
    - NONE: cnt=1. Go to RELEASE_DB, or go directly to IDLE if DEBOUNCE==1.
  - RELEASE_DB:
    - NONE: cnt++. When cnt reaches DEBOUNCE, go to IDLE; key_down=0.
    - Any key present: return to PRESSED with no new key_valid.
- While a key is held, a second or different key is ignored. A new code requires a full release first.
- key_code holds its last accepted value until the next accepted press. It is not cleared on release.

## Timing

- Reset values: COL=4'b1110 (SEL=0), key_code=0, key_valid=0, key_down=0, divider=0, state IDLE, cnt=0, synchronizer flops=4'b1111, frame samples cleared.
- A reset asserted mid-operation takes effect at the next edge. It never produces a key_valid pulse, and it discards any partial frame or debounce count.
- Frame period is 4*CLK_DIV cycles.
- key_valid and the new key_code appear in the cycle after the edge at the end of the DEBOUNCE-th consecutive SINGLE(k) frame. key_valid is high for exactly one clk_50M cycle.
- key_down rises together with key_valid. It falls in the cycle after the end of the DEBOUNCE-th consecutive NONE frame.
- Synchronizer latency is 2 cycles. CLK_DIV ≥ 4 guarantees the row response to a new column is settled before its sample.

## Test plan

- Reset, bench CLK_DIV=4, DEBOUNCE=3: hold rst for 3 cycles, release, idle for 20 cycles.
  - COL sequence 1110, 1101, 1011, 0111, each for 4 cycles, repeating.
  - key_valid and key_down stay 0; key_code=0.
- Clean press of row 2 / column 1: the model pulls ROW[2] low whenever COL[1]=0, held for 6 frames.
  - Exactly one key_valid pulse with key_code=9, after the 3rd full SINGLE frame.
  - key_down=1 until 3 NONE frames after release.
- Bounce: key 9 toggles on and off on alternate frames for 8 frames.
  - No key_valid.
  - Then held steady: key_valid after 3 frames, key_code=9.
- Multi-key and change-while-held:
  - Press keys 0 and 15 together: no key_valid.
  - Press key 5 (accepted, code 5), then add key 10 while holding, then release both: exactly one key_valid, key_code stays 5.
- Reset mid-debounce: assert rst after 2 SINGLE(3) frames.
  - All outputs return to reset values.
  - After release of rst, with key 3 still held, key_valid occurs 3 full frames later with code 3.
- Corner codes with DEBOUNCE=1: press keys 0, then 15, with full releases between.
  - key_code 0 then 15, each with key_valid one frame after the press.
  - key_down falls one frame after release.
